serial_sub_recover: RTL and testbench



---
 rtl/serial_sub_recover.sv | 109 ++++++++++
 tb/tb_serial_sub_recover.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_recover.sv
// serial_sub_recover: bit-serial subtractor that recovers operand a = sum - b
// from a 4-bit adder result and a 3-bit operand. Processes one bit per clock
// using a registered borrow and a start/busy/done handshake. err flags results
// that cannot be a legal 3-bit operand (underflow or bit 3 set).
module serial_sub_recover (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] sum,
    input  logic [2:0] b,
    output logic       busy,
    output logic       done,
    output logic [2:0] a,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_s;        // minuend shift register, LSB consumed first
    logic [3:0]  r_t;        // zero-extended subtrahend shift register
    logic [3:0]  r_r;        // result shift register, new bit enters at bit 3
    logic        r_borrow;
    logic [1:0]  r_cnt;
    logic [2:0]  r_a;
    logic        r_err;

    logic        w_load;
    logic        w_last;
    logic        w_d;
    logic        w_borrow_next;
    logic [3:0]  w_r_final;

    // A request is honoured only from IDLE or DONE; DONE allows back-to-back.
    assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
    // The fourth bit is processed in the cycle where cnt reaches 3.
    assign w_last = (r_state == CALC) && (r_cnt == 2'd3);

    // One full-subtractor slice on the current LSBs.
    assign w_d           = r_s[0] ^ r_t[0] ^ r_borrow;
    assign w_borrow_next = (~r_s[0] & (r_t[0] | r_borrow)) | (r_t[0] & r_borrow);
    assign w_r_final     = {w_d, r_r[3:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is not looked at while in CALC.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CALC;
            CALC:    if (r_cnt == 2'd3) w_state_next = DONE;
            DONE:    w_state_next = start ? CALC : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Serial datapath: capture operands on accept, otherwise shift one bit per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s      <= 4'd0;
            r_t      <= 4'd0;
            r_r      <= 4'd0;
            r_borrow <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (w_load) begin
            r_s      <= sum;
            r_t      <= {1'b0, b};
            r_r      <= 4'd0;
            r_borrow <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (r_state == CALC) begin
            r_s      <= {1'b0, r_s[3:1]};
            r_t      <= {1'b0, r_t[3:1]};
            r_r      <= w_r_final;
            r_borrow <= w_borrow_next;
            r_cnt    <= r_cnt + 2'd1;
        end
    end

    // Result registers update only on completion and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= 3'd0;
            r_err <= 1'b0;
        end else if (w_last) begin
            r_a   <= w_r_final[2:0];
            r_err <= w_r_final[3] | w_borrow_next;
        end
    end

    assign busy = (r_state == CALC);
    assign done = (r_state == DONE);
    assign a    = r_a;
    assign err  = r_err;

endmodule

// File: tb/tb_serial_sub_recover.sv
// Self-checking bench for serial_sub_recover: directed table, handshake corner
// sequences, reset abort, exhaustive round-trip and randomized operations.
module tb_serial_sub_recover;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] sum;
    logic [2:0] b;
    logic       busy;
    logic       done;
    logic [2:0] a;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] sum;
        logic [2:0] b;
        logic [2:0] a;
        logic       err;
    } vec_t;

    vec_t vecs[6];

    serial_sub_recover dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sum   (sum),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .a     (a),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction of the captured operands.
    task automatic ref_sub(input int s, input int bb, output int ea, output int ee);
        int diff;
        diff = s - bb;
        ea   = diff & 7;
        ee   = (diff < 0 || diff > 7) ? 1 : 0;
    endtask

    // Full operation from IDLE: start sampled at edge k, then checks busy for
    // 4 cycles, the done pulse at k+4 and its removal at k+5. Operand inputs are
    // scrambled after capture to prove they are not re-sampled.
    task automatic run_op(input logic [3:0] s, input logic [2:0] bb,
                          input int ea, input int ee, input string tag);
        @(negedge clk);
        sum = s; b = bb; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            sum = 4'($urandom); b = 3'($urandom);
            chk({tag, " busy"}, busy, 1);
            chk({tag, " done_early"}, done, 0);
        end
        @(negedge clk);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " a"}, a, ea);
        chk({tag, " err"}, err, ee);
        @(negedge clk);
        chk({tag, " done_clr"}, done, 0);
        chk({tag, " a_hold"}, a, ea);
    endtask

    initial begin
        int ea, ee;
        vecs[0] = '{sum: 4'd9,  b: 3'd3, a: 3'd6, err: 1'b0};
        vecs[1] = '{sum: 4'd14, b: 3'd7, a: 3'd7, err: 1'b0};
        vecs[2] = '{sum: 4'd0,  b: 3'd0, a: 3'd0, err: 1'b0};
        vecs[3] = '{sum: 4'd2,  b: 3'd5, a: 3'd5, err: 1'b1};
        vecs[4] = '{sum: 4'd15, b: 3'd0, a: 3'd7, err: 1'b1};
        vecs[5] = '{sum: 4'd8,  b: 3'd1, a: 3'd7, err: 1'b0};

        rst_n = 1'b0; start = 1'b0; sum = 4'd0; b = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst a", a, 0);
        chk("rst err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i])
            run_op(vecs[i].sum, vecs[i].b, vecs[i].a, vecs[i].err, $sformatf("vec%0d", i));

        // start reasserted during CALC with other operands is ignored
        @(negedge clk);
        sum = 4'd9; b = 3'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        sum = 4'd2; b = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ign busy", busy, 1);
        @(negedge clk);
        chk("ign done", done, 1);
        chk("ign a", a, 6);
        chk("ign err", err, 0);
        @(negedge clk);
        chk("ign no_restart", busy, 0);
        chk("ign done_clr", done, 0);

        // Back-to-back: start held through DONE restarts without an IDLE cycle
        @(negedge clk);
        sum = 4'd14; b = 3'd7; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b busy1", busy, 1);
        end
        @(negedge clk);
        chk("b2b done1", done, 1);
        chk("b2b a1", a, 7);
        chk("b2b err1", err, 0);
        sum = 4'd2; b = 3'd5;
        @(negedge clk);
        chk("b2b restart busy", busy, 1);
        chk("b2b restart done", done, 0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b busy2", busy, 1);
            chk("b2b a_stable", a, 7);
        end
        @(negedge clk);
        chk("b2b done2", done, 1);
        chk("b2b a2", a, 5);
        chk("b2b err2", err, 1);
        @(negedge clk);
        chk("b2b done2_clr", done, 0);

        // Reset two cycles after start aborts immediately, no done afterwards
        @(negedge clk);
        sum = 4'd9; b = 3'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort a", a, 0);
        chk("abort err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done || busy) seen = 1;
            end
            chk("abort no_done", seen, 0);
        end
        run_op(4'd5, 3'd2, 3, 0, "post_abort");

        // Round-trip: sum = a0 + b recovers a0 with no error
        for (int a0 = 0; a0 < 8; a0++)
            for (int bb = 0; bb < 8; bb++)
                run_op(4'(a0 + bb), 3'(bb), a0, 0, $sformatf("rt a0=%0d b=%0d", a0, bb));

        // All sum/b pairs against the reference
        for (int s = 0; s < 16; s++)
            for (int bb = 0; bb < 8; bb++) begin
                ref_sub(s, bb, ea, ee);
                run_op(4'(s), 3'(bb), ea, ee, $sformatf("all s=%0d b=%0d", s, bb));
            end

        // Random operands with random idle gaps
        for (int n = 0; n < 40; n++) begin
            logic [3:0] rs;
            logic [2:0] rb;
            rs = 4'($urandom);
            rb = 3'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ref_sub(int'(rs), int'(rb), ea, ee);
            run_op(rs, rb, ea, ee, $sformatf("rnd s=%0d b=%0d", rs, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
